reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/types_pkg.sv | 17 +
 rtl/rob_retire_sel.sv | 25 ++
 rtl/reorder_buffer.sv | 185 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the out-of-order backend.
// Holds the reorder-buffer sizing constants and entry layout.
package types_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int PREG_W    = 7;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire lane selector: in-order prefix-AND over the head lanes.
// Ports: lane_ok (per-lane ready) -> ret_valid (no gaps), ret_cnt (popcount).
module rob_retire_sel #(
    parameter int RETIRE_W = 2,
    parameter int CNT_W    = 6
) (
    input  logic [RETIRE_W-1:0] lane_ok,
    output logic [RETIRE_W-1:0] ret_valid,
    output logic [CNT_W-1:0]    ret_cnt
);

    logic run;

    always_comb begin
        run       = 1'b1;
        ret_valid = '0;
        ret_cnt   = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            ret_valid[i] = run & lane_ok[i];
            run          = ret_valid[i];
            ret_cnt      = ret_cnt + CNT_W'(ret_valid[i]);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order alloc, out-of-order complete, in-order retire.
// Ports: alloc_* (rename), cpl_* (completion), flush_* (mispredict),
//        ret_* (retire lanes), count/empty/full (occupancy).
module reorder_buffer
    import types_pkg::PC_W;
#(
    parameter int DEPTH    = types_pkg::ROB_DEPTH,
    parameter int PREG_W   = types_pkg::PREG_W,
    parameter int N_CPL    = 3,
    parameter int RETIRE_W = 2,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [PREG_W-1:0]            alloc_pd_new,
    input  logic [PREG_W-1:0]            alloc_pd_old,
    input  logic [PC_W-1:0]              alloc_pc,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [N_CPL-1:0]             cpl_valid,
    input  logic [N_CPL*TAG_W-1:0]       cpl_tag,
    input  logic                         flush_valid,
    input  logic [TAG_W-1:0]             flush_tag,
    output logic [RETIRE_W-1:0]          ret_valid,
    output logic [RETIRE_W*PREG_W-1:0]   ret_pd_old,
    output logic [RETIRE_W*PREG_W-1:0]   ret_pd_new,
    output logic [RETIRE_W*PC_W-1:0]     ret_pc,
    output logic [TAG_W:0]               count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = TAG_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  occ;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  cmpl_q, cmpl_d;
    logic [DEPTH-1:0]  squash;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_new_d [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [PREG_W-1:0] pd_old_d [DEPTH];
    logic [PC_W-1:0]   pc_q [DEPTH];
    logic [PC_W-1:0]   pc_d [DEPTH];

    logic [TAG_W-1:0]    head_idx;
    logic [TAG_W-1:0]    tail_idx;
    logic [TAG_W-1:0]    off_f;
    logic [TAG_W-1:0]    off_j;
    logic [TAG_W-1:0]    cpl_t;
    logic [TAG_W-1:0]    lane_idx [RETIRE_W];
    logic                full_raw;
    logic                flush_ok;
    logic                alloc_fire;
    logic [RETIRE_W-1:0] lane_ok;
    logic [RETIRE_W-1:0] sel_valid;
    logic [PTR_W-1:0]    ret_cnt;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign occ      = tail_q - head_q;
    assign full_raw = (occ == PTR_W'(DEPTH));

    assign count       = reset ? '0 : occ;
    assign empty       = (count == '0);
    assign full        = !reset && full_raw;
    assign alloc_ready = !reset && !full_raw && !flush_valid;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_idx;

    // A flush naming a dead slot is stale and must not move tail.
    assign flush_ok = flush_valid && valid_q[flush_tag];
    // Age of the flushing entry relative to head; younger means larger.
    assign off_f    = flush_tag - head_idx;

    always_comb begin
        squash = '0;
        off_j  = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off_j     = TAG_W'(j) - head_idx;
            squash[j] = flush_ok && valid_q[j] && (off_j > off_f);
        end
    end

    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            lane_idx[i] = head_idx + TAG_W'(i);
            // Never retire past the flush point, even if already complete.
            lane_ok[i]  = valid_q[lane_idx[i]]
                       && cmpl_q[lane_idx[i]]
                       && (PTR_W'(i) < occ)
                       && !(flush_ok && (TAG_W'(i) > off_f));
        end
    end

    rob_retire_sel #(
        .RETIRE_W (RETIRE_W),
        .CNT_W    (PTR_W)
    ) u_retire_sel (
        .lane_ok   (lane_ok),
        .ret_valid (sel_valid),
        .ret_cnt   (ret_cnt)
    );

    assign ret_valid = reset ? '0 : sel_valid;

    always_comb begin
        ret_pd_old = '0;
        ret_pd_new = '0;
        ret_pc     = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            ret_pd_old[i*PREG_W +: PREG_W] = pd_old_q[lane_idx[i]];
            ret_pd_new[i*PREG_W +: PREG_W] = pd_new_q[lane_idx[i]];
            ret_pc[i*PC_W +: PC_W]         = pc_q[lane_idx[i]];
        end
    end

    always_comb begin
        valid_d  = valid_q;
        cmpl_d   = cmpl_q;
        pd_new_d = pd_new_q;
        pd_old_d = pd_old_q;
        pc_d     = pc_q;
        cpl_t    = '0;

        for (int p = 0; p < N_CPL; p++) begin
            cpl_t = cpl_tag[p*TAG_W +: TAG_W];
            if (cpl_valid[p] && valid_q[cpl_t]) begin
                cmpl_d[cpl_t] = 1'b1;
            end
        end

        for (int i = 0; i < RETIRE_W; i++) begin
            if (sel_valid[i]) begin
                valid_d[lane_idx[i]] = 1'b0;
                cmpl_d[lane_idx[i]]  = 1'b0;
            end
        end

        // Squash last so completions to younger entries are dropped.
        valid_d = valid_d & ~squash;
        cmpl_d  = cmpl_d & ~squash;

        if (alloc_fire) begin
            valid_d[tail_idx]  = 1'b1;
            cmpl_d[tail_idx]   = 1'b0;
            pd_new_d[tail_idx] = alloc_pd_new;
            pd_old_d[tail_idx] = alloc_pd_old;
            pc_d[tail_idx]     = alloc_pc;
        end

        head_d = head_q + ret_cnt;
        if (flush_ok) begin
            tail_d = head_q + {1'b0, off_f} + PTR_W'(1);
        end else begin
            tail_d = tail_q + PTR_W'(alloc_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            cmpl_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            cmpl_q  <= cmpl_d;
        end
    end

    // Payload is only meaningful under valid, so it is never reset.
    always_ff @(posedge clk) begin
        pd_new_q <= pd_new_d;
        pd_old_q <= pd_old_d;
        pc_q     <= pc_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer at DEPTH=8, RETIRE_W=2.
// Queue-based reference model plus directed literal scenarios.
module tb_reorder_buffer;
    import types_pkg::*;

    localparam int DEPTH = 8;
    localparam int RW    = 2;
    localparam int NC    = 3;
    localparam int PW    = 7;
    localparam int TW    = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [PW-1:0]    alloc_pd_new;
    logic [PW-1:0]    alloc_pd_old;
    logic [31:0]      alloc_pc;
    logic [TW-1:0]    alloc_tag;
    logic [NC-1:0]    cpl_valid;
    logic [NC*TW-1:0] cpl_tag;
    logic             flush_valid;
    logic [TW-1:0]    flush_tag;
    logic [RW-1:0]    ret_valid;
    logic [RW*PW-1:0] ret_pd_old;
    logic [RW*PW-1:0] ret_pd_new;
    logic [RW*32-1:0] ret_pc;
    logic [TW:0]      count;
    logic             empty;
    logic             full;

    always #5 clk = ~clk;

    reorder_buffer #(
        .DEPTH    (DEPTH),
        .PREG_W   (PW),
        .N_CPL    (NC),
        .RETIRE_W (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_pd_new (alloc_pd_new),
        .alloc_pd_old (alloc_pd_old),
        .alloc_pc     (alloc_pc),
        .alloc_tag    (alloc_tag),
        .cpl_valid    (cpl_valid),
        .cpl_tag      (cpl_tag),
        .flush_valid  (flush_valid),
        .flush_tag    (flush_tag),
        .ret_valid    (ret_valid),
        .ret_pd_old   (ret_pd_old),
        .ret_pd_new   (ret_pd_new),
        .ret_pc       (ret_pc),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    typedef struct {
        int         seq;
        rob_entry_t e;
    } ment_t;

    ment_t mq[$];
    int    tail_seq = 0;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: the ROB is an ordered list of live entries, each
    // tagged by its allocation sequence number modulo DEPTH.
    always @(negedge clk) begin : cmp
        int n;
        int k;
        bit rdy;
        logic [RW-1:0] ev;
        ment_t ne;
        if (reset) begin
            chk("m_rst_count", count, 0);
            chk("m_rst_empty", empty, 1);
            chk("m_rst_full", full, 0);
            chk("m_rst_ready", alloc_ready, 0);
            chk("m_rst_ret", ret_valid, 0);
            mq.delete();
            tail_seq = 0;
        end else begin
            n = 0;
            for (int i = 0; i < RW; i++)
                if (i < mq.size() && n == i && mq[i].e.complete) n++;
            k = -1;
            if (flush_valid)
                for (int j = 0; j < mq.size(); j++)
                    if (mq[j].seq % DEPTH == int'(flush_tag)) k = j;
            if (k >= 0 && n > k + 1) n = k + 1;
            ev  = RW'((1 << n) - 1);
            rdy = (mq.size() < DEPTH) && !flush_valid;
            chk("m_count", count, mq.size());
            chk("m_empty", empty, mq.size() == 0);
            chk("m_full", full, mq.size() == DEPTH);
            chk("m_ready", alloc_ready, rdy);
            chk("m_tag", alloc_tag, tail_seq % DEPTH);
            chk("m_ret", ret_valid, ev);
            for (int i = 0; i < n; i++) begin
                chk("m_ret_pc", ret_pc[i*32 +: 32], mq[i].e.pc);
                chk("m_ret_old", ret_pd_old[i*PW +: PW], mq[i].e.pd_old);
                chk("m_ret_new", ret_pd_new[i*PW +: PW], mq[i].e.pd_new);
            end
            for (int p = 0; p < NC; p++)
                if (cpl_valid[p])
                    for (int j = 0; j < mq.size(); j++)
                        if (mq[j].seq % DEPTH == int'(cpl_tag[p*TW +: TW])
                            && (k < 0 || j <= k))
                            mq[j].e.complete = 1'b1;
            if (k >= 0) begin
                tail_seq = mq[k].seq + 1;
                while (mq.size() > k + 1) void'(mq.pop_back());
            end
            repeat (n) void'(mq.pop_front());
            if (alloc_valid && rdy) begin
                ne.seq        = tail_seq;
                ne.e.valid    = 1'b1;
                ne.e.complete = 1'b0;
                ne.e.pd_new   = alloc_pd_new;
                ne.e.pd_old   = alloc_pd_old;
                ne.e.pc       = alloc_pc;
                mq.push_back(ne);
                tail_seq++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid  = 1'b0;
        alloc_pd_new = '0;
        alloc_pd_old = '0;
        alloc_pc     = '0;
        cpl_valid    = '0;
        cpl_tag      = '0;
        flush_valid  = 1'b0;
        flush_tag    = '0;
    endtask

    task automatic set_alloc(logic [31:0] pc);
        alloc_valid  = 1'b1;
        alloc_pc     = pc;
        alloc_pd_new = pc[6:0];
        alloc_pd_old = ~pc[6:0];
    endtask

    task automatic cpl(int p, int t);
        cpl_valid[p]         = 1'b1;
        cpl_tag[p*TW +: TW]  = TW'(t);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_ready", alloc_ready, 0);
        chk("rst_empty", empty, 1);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", alloc_ready, 1);
        chk("post_rst_count", count, 0);

        // Fill to capacity, then a 9th request is refused.
        for (int i = 0; i < 8; i++) begin
            set_alloc(32'h100 + i);
            #1;
            chk("fill_tag", alloc_tag, i);
            tick();
        end
        #1;
        chk("fill_full", full, 1);
        chk("fill_ready", alloc_ready, 0);
        chk("fill_count", count, 8);
        tick();
        #1;
        chk("fill_9th_count", count, 8);

        // Full with head completing: no alloc credit that cycle.
        idle();
        cpl(0, 0);
        tick();
        idle();
        set_alloc(32'h180);
        #1;
        chk("fullret_ready", alloc_ready, 0);
        chk("fullret_ret", ret_valid, 2'b01);
        chk("fullret_pc", ret_pc[31:0], 32'h100);
        tick();
        #1;
        chk("fullret_ready2", alloc_ready, 1);
        chk("fullret_count", count, 7);

        // Out-of-order completion, in-order retire.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'h200 + i);
            tick();
        end
        idle();
        for (int t = 3; t >= 1; t--) begin
            cpl(0, t);
            tick();
            idle();
            #1;
            chk("ooo_hold", ret_valid, 0);
        end
        cpl(0, 0);
        #1;
        chk("ooo_lat", ret_valid, 0);
        tick();
        idle();
        #1;
        chk("ooo_ret01", ret_valid, 2'b11);
        chk("ooo_pc0", ret_pc[31:0], 32'h200);
        chk("ooo_pc1", ret_pc[63:32], 32'h201);
        tick();
        #1;
        chk("ooo_ret23", ret_valid, 2'b11);
        chk("ooo_pc2", ret_pc[31:0], 32'h202);
        tick();
        #1;
        chk("ooo_empty", empty, 1);

        // Wrap around the end of the ring.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(32'h2f0 + i);
            tick();
        end
        idle();
        cpl(0, 0); cpl(1, 1); cpl(2, 2);
        tick();
        idle();
        cpl(0, 3); cpl(1, 4); cpl(2, 5);
        tick();
        idle();
        for (int w = 0; w < 10 && !empty; w++) tick();
        chk("wrap_pre_empty", empty, 1);
        chk("wrap_pre_tag", alloc_tag, 6);
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'h300 + i);
            #1;
            chk("wrap_tag", alloc_tag, (6 + i) % 8);
            tick();
        end
        idle();
        cpl(0, 6); cpl(1, 7); cpl(2, 0);
        tick();
        idle();
        cpl(0, 1);
        #1;
        chk("wrap_ret_a", ret_valid, 2'b11);
        chk("wrap_pc6", ret_pc[31:0], 32'h300);
        chk("wrap_pc7", ret_pc[63:32], 32'h301);
        tick();
        idle();
        #1;
        chk("wrap_ret_b", ret_valid, 2'b11);
        chk("wrap_pc0", ret_pc[31:0], 32'h302);
        chk("wrap_pc1", ret_pc[63:32], 32'h303);
        tick();
        #1;
        chk("wrap_empty", count, 0);
        chk("wrap_tag_after", alloc_tag, 2);

        // Flush with concurrent completions and alloc attempt.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(32'h400 + i);
            tick();
        end
        idle();
        set_alloc(32'h4ff);
        flush_valid = 1'b1;
        flush_tag   = 3'd2;
        cpl(0, 1);
        cpl(1, 4);
        #1;
        chk("flush_ready", alloc_ready, 0);
        tick();
        idle();
        #1;
        chk("flush_count", count, 3);
        chk("flush_tag_next", alloc_tag, 3);
        chk("flush_ret", ret_valid, 0);
        cpl(0, 0);
        tick();
        idle();
        #1;
        chk("flush_ret01", ret_valid, 2'b11);
        chk("flush_pc1", ret_pc[63:32], 32'h401);
        tick();
        #1;
        chk("flush_count2", count, 1);
        chk("flush_ret2", ret_valid, 0);

        // Reset mid-stream, then a stale flush.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(32'h500 + i);
            tick();
        end
        idle();
        cpl(0, 0);
        cpl(1, 1);
        tick();
        idle();
        #1;
        chk("mid_pre_ret", ret_valid, 2'b11);
        reset = 1'b1;
        #1;
        chk("mid_in_rst_ret", ret_valid, 0);
        chk("mid_in_rst_ready", alloc_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_count", count, 0);
        chk("mid_ret", ret_valid, 0);
        flush_valid = 1'b1;
        flush_tag   = 3'd2;
        tick();
        idle();
        #1;
        chk("stale_count", count, 0);
        chk("stale_tag", alloc_tag, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset        = ($urandom_range(0, 399) == 0);
            alloc_valid  = ($urandom_range(0, 9) < 7);
            alloc_pc     = $urandom;
            alloc_pd_new = PW'($urandom);
            alloc_pd_old = PW'($urandom);
            for (int p = 0; p < NC; p++) begin
                cpl_valid[p]        = $urandom_range(0, 1) == 1;
                cpl_tag[p*TW +: TW] = TW'($urandom_range(0, 7));
            end
            flush_valid = ($urandom_range(0, 24) == 0);
            flush_tag   = TW'($urandom_range(0, 7));
        end
        tick();
        idle();
        reset = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
